// File: rtl/booth_seq_multiplier_pkg.sv
// Shared arithmetic definitions for the sequential radix-4 Booth multiplier.
// Holds the FSM state type, digit-count helper and Booth window width.
package booth_seq_multiplier_pkg;

  localparam int BOOTH_WIN = 3;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic int n_digits(input int w);
    return w / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_seq_multiplier_if.sv
// Operand/product valid-ready bundle for booth_seq_multiplier.
// master drives operands and accepts products; slave is the multiplier.
interface booth_seq_multiplier_if #(
  parameter int WIDTH = 32
);

  logic               in_valid;
  logic               in_ready;
  logic               unsign;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid,
    output unsign,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  unsign,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product,
    output busy
  );

endinterface

// File: rtl/booth_encoder.sv
// Radix-4 Booth digit encoder: picts one of 0/+1x/+2x/-1x/-2x from a window.
// Negative picks return the inverted operand with s=1 to finish the negation.
module booth_encoder
  import booth_seq_multiplier_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PIPE_STAGE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BOOTH_WIN-1:0] sel,
  input  logic [WIDTH:0]       x1,
  input  logic [WIDTH:0]       x2,
  input  logic [WIDTH:0]       neg,
  input  logic [WIDTH:0]       neg_2x,
  output logic [WIDTH:0]       pp_out,
  output logic                 s,
  output logic                 p
);

  logic [WIDTH:0] pp_c;
  logic           s_c;
  logic           p_c;
  logic [WIDTH:0] pp_q;
  logic           s_q;
  logic           p_q;

  always_comb begin
    pp_c = '0;
    s_c  = 1'b0;
    p_c  = 1'b1;
    unique case (1'b1)
      (sel == 3'b001),
      (sel == 3'b010): pp_c = x1;
      (sel == 3'b011): pp_c = x2;
      (sel == 3'b100): begin
        pp_c = neg_2x;
        s_c  = 1'b1;
      end
      (sel == 3'b101),
      (sel == 3'b110): begin
        pp_c = neg;
        s_c  = 1'b1;
      end
      default: p_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_q <= '0;
      s_q  <= 1'b0;
      p_q  <= 1'b0;
    end else begin
      pp_q <= pp_c;
      s_q  <= s_c;
      p_q  <= p_c;
    end
  end

  // Registered copy is only selected when a pipeline stage is requested.
  assign pp_out = (PIPE_STAGE != 0) ? pp_q : pp_c;
  assign s      = (PIPE_STAGE != 0) ? s_q  : s_c;
  assign p      = (PIPE_STAGE != 0) ? p_q  : p_c;

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-4 Booth multiplier, one partial product per cycle.
// Define BOOTH_SEQ_EARLY_TERM_EN to finish once remaining digits are zero.
module booth_seq_multiplier
  import booth_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  booth_seq_multiplier_if.slave bus
);

  localparam int N_DIGITS = n_digits(WIDTH);
  localparam int XW       = 2 * WIDTH + 2;
  localparam int MW       = WIDTH + 3;
  localparam int CW       = $clog2(N_DIGITS + 1);

  state_t        state;
  logic [XW-1:0] mcand;
  logic [XW-1:0] acc;
  logic [MW-1:0] mplr;
  logic [CW-1:0] cnt;

  logic [XW-1:0] x2;
  logic [XW-1:0] pp;
  logic          s;
  logic          p;
  logic [XW-1:0] acc_nxt;
  logic          last;
  logic          ext_b;

  assign x2      = {mcand[XW-2:0], 1'b0};
  assign acc_nxt = acc + pp + {{(XW-1){1'b0}}, s};
  assign ext_b   = bus.b[WIDTH-1] & ~bus.unsign;

`ifdef BOOTH_SEQ_EARLY_TERM_EN
  // A register of all-equal bits only yields zero digits from here on.
  assign last = (cnt == CW'(N_DIGITS - 1))
              || (&mplr) || (~|mplr);
`else
  assign last = (cnt == CW'(N_DIGITS - 1));
`endif

  booth_encoder #(
    .WIDTH      (XW - 1),
    .PIPE_STAGE (0)
  ) u_enc (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel    (mplr[BOOTH_WIN-1:0]),
    .x1     (mcand),
    .x2     (x2),
    .neg    (~mcand),
    .neg_2x (~x2),
    .pp_out (pp),
    .s      (s),
    .p      (p)
  );

  zero_digit_a: assert property (
    @(posedge clk) disable iff (!rst_n)
    !p |-> (pp == '0) && !s
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.product   <= '0;
      acc           <= '0;
      cnt           <= '0;
      mcand         <= '0;
      mplr          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand <= bus.unsign
                   ? {{(XW-WIDTH){1'b0}}, bus.a}
                   : {{(XW-WIDTH){bus.a[WIDTH-1]}}, bus.a};
            mplr  <= {ext_b, ext_b, bus.b, 1'b0};
            acc          <= '0;
            cnt          <= '0;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= BUSY;
          end
        end
        BUSY: begin
          acc   <= acc_nxt;
          mcand <= {mcand[XW-3:0], 2'b00};
          mplr  <= {{2{mplr[MW-1]}}, mplr[MW-1:2]};
          cnt   <= cnt + CW'(1);
          if (last) begin
            bus.out_valid <= 1'b1;
            bus.product   <= acc_nxt[2*WIDTH-1:0];
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed bench for booth_seq_multiplier at WIDTH=8.
// Table of operand/product vectors plus handshake, backpressure and reset cases.
module tb_booth_seq_multiplier;

  localparam int W  = 8;
  localparam int ND = 5;
`ifdef BOOTH_SEQ_EARLY_TERM_EN
  localparam int B1_LAT = 2;
`else
  localparam int B1_LAT = 5;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  booth_seq_multiplier_if #(.WIDTH(W)) bus ();

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        u;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic u,
                       input logic [7:0] a,
                       input logic [7:0] b);
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.unsign   = u;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    // Flipping unsign after acceptance must not alter the result.
    bus.unsign   = ~u;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 20);
    chk("done_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic handoff();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("handoff_in_ready", 32'(bus.in_ready), 32'd1);
    chk("handoff_out_valid", 32'(bus.out_valid), 32'd0);
    chk("handoff_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic run_op(input string name,
                        input logic u,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [15:0] exp,
                        input int exp_lat);
    int lat;
    issue(u, a, b);
    wait_done(lat);
    chk(name, 32'(bus.product), 32'(exp));
    if (exp_lat > 0)
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_busy"}, 32'(bus.busy), 32'd1);
    handoff();
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[1] = '{1'b1, 8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{1'b0, 8'hFF, 8'hFF, 16'h0001};
    vecs[3] = '{1'b0, 8'h07, 8'hFD, 16'hFFEB};
    vecs[4] = '{1'b0, 8'h00, 8'h55, 16'h0000};
    vecs[5] = '{1'b1, 8'h80, 8'h02, 16'h0100};
    vecs[6] = '{1'b0, 8'h80, 8'h7F, 16'hC080};
    vecs[7] = '{1'b0, 8'h7F, 8'h7F, 16'h3F01};
    vecs[8] = '{1'b1, 8'h7F, 8'h81, 16'h3FFF};
    vecs[9] = '{1'b0, 8'hFF, 8'h80, 16'h0080};

    bus.in_valid  = 1'b0;
    bus.unsign    = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
`ifdef BOOTH_SEQ_EARLY_TERM_EN
      run_op($sformatf("vec%0d", i), vecs[i].u,
             vecs[i].a, vecs[i].b, vecs[i].exp, 0);
`else
      run_op($sformatf("vec%0d", i), vecs[i].u,
             vecs[i].a, vecs[i].b, vecs[i].exp, ND);
`endif
    end

    run_op("a5_b1", 1'b0, 8'd5, 8'd1, 16'h0005, B1_LAT);

    // out_ready with nothing pending must be ignored
    @(negedge clk);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ready_out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_ready_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;

    // backpressure with a stray request during DONE
    begin
      int lat;
      issue(1'b0, 8'd3, 8'd4);
      wait_done(lat);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (i == 2) begin
          bus.in_valid = 1'b1;
          bus.a        = 8'd9;
          bus.b        = 8'd9;
        end
        if (i == 5) bus.in_valid = 1'b0;
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_product", 32'(bus.product), 32'd12);
      end
      handoff();
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        chk("bp_not_queued", 32'(bus.busy), 32'd0);
      end
    end

    // reset in the 3rd BUSY cycle
    issue(1'b0, 8'd6, 8'd7);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_product", 32'(bus.product), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_output", 32'(bus.out_valid), 32'd0);
    end
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    run_op("post_rst_3x5", 1'b0, 8'd3, 8'd5, 16'd15, 0);
`else
    run_op("post_rst_3x5", 1'b0, 8'd3, 8'd5, 16'd15, ND);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
